// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
// Shared definitions for the frequency meter slice.
//   state_t              : FSM state encoding used by freq_meter
//   DEFAULT_GATE_CYCLES  : default gate window length in clk cycles. The clock
//                          divider uses the same value as its terminal count, so
//                          a divider output measured here reads back as one
//                          edge per window.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_GATE_CYCLES = 500_000;

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// sync_edge_detect
// Brings an asynchronous slow signal into the clk domain and flags its rising
// edges.
//   clk    in  system clock, all flops on posedge
//   reset  in  asynchronous active-low reset (asserted when 0)
//   sig_in in  asynchronous input signal
//   rise   out single-cycle pulse, one per synchronized rising edge of sig_in
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig_in,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   // s1/s2 form the metastability synchronizer. s3 remembers the previous
   // synchronized value so a 0->1 step can be spotted. The chain runs in every
   // FSM state so history is always valid when a window opens.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
// Counts rising edges of a slow asynchronous signal over a fixed gate window
// of GATE_CYCLES clk cycles and publishes one result per window.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset (asserted when 0)
//   en     in  measurement enable (level)
//   sig_in in  asynchronous signal under measurement
//   count  out rising edges counted in the last completed window
//   valid  out one-cycle strobe, count/ovf updated on this cycle
//   ovf    out last completed window saturated the edge counter
//   busy   out high while a gate window is open
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned GATE_W      = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] count,
   output logic             valid,
   output logic             ovf,
   output logic             busy
);

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t              state;
   state_t              next_state;
   logic [GATE_W-1:0]   gate_cnt;
   logic [CNT_W-1:0]    edge_cnt;
   logic                sat;
   logic                rise;

   sync_edge_detect u_sync (
      .clk    (clk),
      .reset  (reset),
      .sig_in (sig_in),
      .rise   (rise)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Dropping en during a window aborts it straight back to
   // IDLE, taking priority over the end-of-window check so a window abandoned
   // on its last cycle is never published. DONE lasts exactly one cycle and
   // chains into a new window when en is still high.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (en) begin
               next_state = MEASURE;
            end
         end
         MEASURE: begin
            if (!en) begin
               next_state = IDLE;
            end else if (gate_cnt == GATE_LAST) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = en ? MEASURE : IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign busy = (state == MEASURE);

   // Gate and edge counters. They only run in MEASURE and sit at zero in every
   // other state, so each window starts clean. A rise on the final gate cycle
   // is still counted because the count register is loaded a cycle later in
   // DONE. Once the edge counter reaches all-ones it holds and further rises
   // only set the saturation flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
      end else begin
         case (state)
            MEASURE: begin
               gate_cnt <= gate_cnt + GATE_W'(1);
               if (rise) begin
                  if (edge_cnt == CNT_MAX) begin
                     sat <= 1'b1;
                  end else begin
                     edge_cnt <= edge_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               sat      <= 1'b0;
            end
         endcase
      end
   end

   // Result registers. Loaded only from DONE, so an aborted window leaves the
   // previous result in place. valid is registered alongside count/ovf so all
   // three change on the same edge, and since DONE never repeats back to back
   // valid can never be high for two cycles in a row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         ovf   <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= (state == DONE);
         if (state == DONE) begin
            count <= edge_cnt;
            ovf   <= sat;
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
// Self-checking bench for freq_meter. Two instances share clock, reset and
// sig_in: dut_a has a 16-bit counter, dut_b a 4-bit counter for saturation.
// Both use a 100-cycle gate window.
module tb_freq_meter;

   localparam int GATE    = 100;
   localparam int CNT_W_A = 16;
   localparam int CNT_W_B = 4;
   localparam int LAT     = GATE + 1;

   logic        clk;
   logic        reset;
   logic        sig_in;
   logic        en_a;
   logic        en_b;
   logic [15:0] count_a;
   logic        valid_a;
   logic        ovf_a;
   logic        busy_a;
   logic [3:0]  count_b;
   logic        valid_b;
   logic        ovf_b;
   logic        busy_b;

   int checks = 0;
   int fails  = 0;
   int period = 0;
   int phase  = 0;
   int cyc    = 0;

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(CNT_W_A), .GATE_W(7)) dut_a (
      .clk    (clk),
      .reset  (reset),
      .en     (en_a),
      .sig_in (sig_in),
      .count  (count_a),
      .valid  (valid_a),
      .ovf    (ovf_a),
      .busy   (busy_a)
   );

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(CNT_W_B), .GATE_W(7)) dut_b (
      .clk    (clk),
      .reset  (reset),
      .en     (en_b),
      .sig_in (sig_in),
      .count  (count_b),
      .valid  (valid_b),
      .ovf    (ovf_b),
      .busy   (busy_b)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Periodic sig_in source: one rising edge every 'period' cycles, shifted by
   // 'phase'. period 0 holds the line low. Updated on the falling edge so the
   // DUT always samples a settled value.
   initial begin
      sig_in = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (period == 0) begin
            sig_in = 1'b0;
         end else begin
            sig_in = ((cyc + phase) % period) < (period / 2);
         end
      end
   end

   // Reference model: a periodic input whose period divides the window gives
   // exactly GATE/period edges, clipped at the counter's all-ones value.
   function automatic int model_count(input int per, input int cnt_w);
      int edges;
      int top;
      edges = GATE / per;
      top   = (1 << cnt_w) - 1;
      return (edges > top) ? top : edges;
   endfunction

   function automatic int model_ovf(input int per, input int cnt_w);
      int edges;
      int top;
      edges = GATE / per;
      top   = (1 << cnt_w) - 1;
      return (edges > top) ? 1 : 0;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Counts posedges until the selected valid is seen (sampled #1 after the
   // edge); gives up after 400 cycles so a missing strobe shows up as a wrong
   // latency instead of a hang.
   task automatic wait_next_valid(input bit use_b, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (((use_b ? valid_b : valid_a) !== 1'b1) && (n < 400));
   endtask

   // Called just after en was raised on a falling edge: the next posedge is
   // where en is first sampled, latency is counted from there.
   task automatic wait_valid(input bit use_b, output int n);
      @(posedge clk);
      wait_next_valid(use_b, n);
   endtask

   // One isolated window: idle, set the input, enable, check the result.
   task automatic apply_stimulus(input bit use_b, input int per, input int ph, input string tag);
      int n;
      int cw;
      cw    = use_b ? CNT_W_B : CNT_W_A;
      en_a  = 1'b0;
      en_b  = 1'b0;
      period = per;
      phase  = ph;
      repeat (12) @(negedge clk);
      if (use_b) en_b = 1'b1;
      else       en_a = 1'b1;
      wait_valid(use_b, n);
      check_output({tag, "_latency"}, n, LAT);
      check_output({tag, "_count"}, use_b ? 32'(count_b) : 32'(count_a), model_count(per, cw));
      check_output({tag, "_ovf"}, use_b ? 32'(ovf_b) : 32'(ovf_a), model_ovf(per, cw));
      @(posedge clk);
      #1;
      check_output({tag, "_valid_single"}, use_b ? 32'(valid_b) : 32'(valid_a), 0);
      @(negedge clk);
      en_a = 1'b0;
      en_b = 1'b0;
   endtask

   initial begin
      int n;
      int seen;
      int divs[7];
      int per;
      divs = '{2, 4, 5, 10, 20, 25, 50};

      // Reset and idle
      en_a  = 1'b0;
      en_b  = 1'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      period = 6;
      repeat (5) begin
         @(posedge clk);
         #1;
         check_output("reset_outputs", {count_a, valid_a, ovf_a, busy_a, count_b, valid_b, ovf_b, busy_b}, 0);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (50) begin
         @(posedge clk);
         #1;
         check_output("idle_outputs", {count_a, valid_a, ovf_a, busy_a, count_b, valid_b, ovf_b, busy_b}, 0);
      end
      $display("[TB] reset/idle done");

      // Basic rate, back-to-back windows
      period = 10;
      phase  = 0;
      repeat (12) @(negedge clk);
      en_a = 1'b1;
      @(posedge clk);
      #1;
      check_output("basic_busy", busy_a, 1);
      wait_next_valid(1'b0, n);
      check_output("basic_first_latency", n, LAT);
      check_output("basic_first_count", count_a, model_count(10, CNT_W_A));
      check_output("basic_first_ovf", ovf_a, 0);
      for (int k = 0; k < 2; k++) begin
         wait_next_valid(1'b0, n);
         check_output("basic_period", n, LAT);
         check_output("basic_count", count_a, model_count(10, CNT_W_A));
      end
      @(negedge clk);
      en_a = 1'b0;
      $display("[TB] basic rate done");

      // Phase independence
      for (int ph = 0; ph < 10; ph++) begin
         apply_stimulus(1'b0, 10, ph, "phase");
      end

      // Randomized periods and phases
      for (int r = 0; r < 6; r++) begin
         per = divs[$urandom_range(0, 6)];
         apply_stimulus(1'b0, per, int'($urandom_range(0, 49)), "rand_a");
      end
      for (int r = 0; r < 3; r++) begin
         per = divs[$urandom_range(0, 6)];
         apply_stimulus(1'b1, per, int'($urandom_range(0, 49)), "rand_b");
      end
      $display("[TB] phase/random windows done");

      // Saturation, then recovery at a slower rate
      period = 4;
      phase  = 0;
      repeat (12) @(negedge clk);
      en_b = 1'b1;
      wait_valid(1'b1, n);
      check_output("sat_latency", n, LAT);
      check_output("sat_count", count_b, model_count(4, CNT_W_B));
      check_output("sat_ovf", ovf_b, model_ovf(4, CNT_W_B));
      @(negedge clk);
      period = 20;
      wait_next_valid(1'b1, n);
      check_output("sat_mixed_period", n, LAT);
      wait_next_valid(1'b1, n);
      check_output("sat_recover_period", n, LAT);
      check_output("sat_recover_count", count_b, model_count(20, CNT_W_B));
      check_output("sat_recover_ovf", ovf_b, model_ovf(20, CNT_W_B));
      @(negedge clk);
      en_b = 1'b0;
      $display("[TB] saturation done");

      // Abort mid-window
      apply_stimulus(1'b0, 10, 3, "pre_abort");
      @(negedge clk);
      en_a = 1'b1;
      @(posedge clk);
      repeat (50) @(posedge clk);
      #1;
      check_output("abort_busy_before", busy_a, 1);
      @(negedge clk);
      en_a = 1'b0;
      @(posedge clk);
      #1;
      check_output("abort_busy_after", busy_a, 0);
      seen = 0;
      repeat (150) begin
         @(posedge clk);
         #1;
         if (valid_a === 1'b1) seen++;
      end
      check_output("abort_no_valid", seen, 0);
      check_output("abort_count_hold", count_a, 10);
      check_output("abort_ovf_hold", ovf_a, 0);
      @(negedge clk);
      en_a = 1'b1;
      wait_valid(1'b0, n);
      check_output("abort_restart_latency", n, LAT);
      check_output("abort_restart_count", count_a, 10);
      @(negedge clk);
      en_a = 1'b0;
      $display("[TB] abort done");

      // Asynchronous reset in the middle of a window
      repeat (5) @(negedge clk);
      en_a = 1'b1;
      @(posedge clk);
      repeat (60) @(posedge clk);
      #2;
      check_output("areset_pre_busy", busy_a, 1);
      check_output("areset_pre_count", count_a, 10);
      #1 reset = 1'b0;
      #1;
      check_output("areset_outputs", {count_a, valid_a, ovf_a, busy_a, count_b, valid_b, ovf_b, busy_b}, 0);
      repeat (3) @(negedge clk);
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         #1;
         if (sig_in === 1'b0) break;
      end
      reset = 1'b1;
      wait_valid(1'b0, n);
      check_output("areset_restart_latency", n, LAT);
      check_output("areset_restart_count", count_a, 10);
      check_output("areset_restart_ovf", ovf_a, 0);
      @(negedge clk);
      en_a = 1'b0;
      $display("[TB] async reset done");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
